// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package regfile_pkg;

    // Power-up clear sequence followed by normal operation.
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Address width for a given register count.
    function automatic int calc_aw(input int nreg);
        return $clog2(nreg);
    endfunction

endpackage

// File: rtl/regfile_bypass.sv
// One read port: picks the highest-index matching write, else stored data.
// Latency: combinational.
// Backpressure: none; outputs forced to 0 outside RUN and for address 0.
module regfile_bypass #(
    parameter int XLEN = 32,
    parameter int AW   = 5,
    parameter int NWR  = 2
) (
    input  logic                i_run,
    input  logic [AW-1:0]       i_rd_addr,
    input  logic [NWR-1:0]      i_wr_en,
    input  logic [NWR*AW-1:0]   i_wr_addr,
    input  logic [NWR*XLEN-1:0] i_wr_data,
    input  logic [XLEN-1:0]     i_stored,
`ifdef RF_SCOREBOARD_EN
    output logic                o_hit,
`endif
    output logic [XLEN-1:0]     o_rd_data
);

    logic w_hit;

    // Ascending scan so a later (higher-index) port overrides an earlier match.
    always_comb begin
        w_hit     = 1'b0;
        o_rd_data = '0;
        if (i_run && (i_rd_addr != '0)) begin
            o_rd_data = i_stored;
            for (int j = 0; j < NWR; j++) begin
                if (i_wr_en[j] && (i_wr_addr[j*AW +: AW] == i_rd_addr)) begin
                    w_hit     = 1'b1;
                    o_rd_data = i_wr_data[j*XLEN +: XLEN];
                end
            end
        end
    end

`ifdef RF_SCOREBOARD_EN
    assign o_hit = w_hit;
`endif

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file, zero-latency reads with write bypass, r0 hardwired to 0.
// Latency: reads combinational, writes land at next posedge; clear takes NREG-1 cycles.
// Backpressure: none; writes ignored while clearing. Optional RF_SCOREBOARD_EN adds busy bits.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int XLEN = 32,
    parameter  int NREG = 32,
    parameter  int NRD  = 2,
    parameter  int NWR  = 2,
    localparam int AW   = calc_aw(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
`ifdef RF_SCOREBOARD_EN
    input  logic                sb_set_en,
    input  logic [AW-1:0]       sb_set_addr,
    output logic [NRD-1:0]      rd_busy,
`endif
    output logic                init_done
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_cnt;
    logic [AW-1:0]   w_cnt_nxt;
    logic            w_clr_we;
    logic            w_run;
    logic [XLEN-1:0] r_mem [NREG];

    assign w_run     = (r_state == RUN);
    assign init_done = w_run;

    // State and clear-counter registers; reset restarts the clear from entry 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CLEAR;
            r_cnt   <= AW'(1);
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state: walk the counter through 1..NREG-1, leave CLEAR on the last write.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_clr_we    = 1'b0;
        case (r_state)
            CLEAR: begin
                w_clr_we  = 1'b1;
                w_cnt_nxt = r_cnt + AW'(1);
                if (r_cnt == AW'(NREG - 1)) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_state_nxt = RUN;
            end
            default: begin
                w_state_nxt = CLEAR;
            end
        endcase
    end

    // Array storage: no reset; zeroed only by the clear walk. Higher port wins on collision.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[r_cnt] <= '0;
        end else if (w_run) begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && (wr_addr[j*AW +: AW] != '0)) begin
                    r_mem[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
                end
            end
        end
    end

`ifdef RF_SCOREBOARD_EN
    logic [NREG-1:0] r_busy;
    logic [NRD-1:0]  w_hit;

    // Pending-write bits: writes clear, a same-cycle set overrides; entry 0 never set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else if (w_run) begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j]) begin
                    r_busy[wr_addr[j*AW +: AW]] <= 1'b0;
                end
            end
            if (sb_set_en && (sb_set_addr != '0)) begin
                r_busy[sb_set_addr] <= 1'b1;
            end
        end
    end
`endif

    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
        logic [XLEN-1:0] w_stored;
        assign w_stored = r_mem[rd_addr[gi*AW +: AW]];

        regfile_bypass #(
            .XLEN (XLEN),
            .AW   (AW),
            .NWR  (NWR)
        ) u_bypass (
            .i_run     (w_run),
            .i_rd_addr (rd_addr[gi*AW +: AW]),
            .i_wr_en   (wr_en),
            .i_wr_addr (wr_addr),
            .i_wr_data (wr_data),
            .i_stored  (w_stored),
`ifdef RF_SCOREBOARD_EN
            .o_hit     (w_hit[gi]),
`endif
            .o_rd_data (rd_data[gi*XLEN +: XLEN])
        );

`ifdef RF_SCOREBOARD_EN
        assign rd_busy[gi] = w_run & ~w_hit[gi] & r_busy[rd_addr[gi*AW +: AW]];
`endif
    end

endmodule
